data_mem_requester: RTL

- Initiator-side controller for the data memory unit. It drives Address, Write_Data and MemWrite, and captures Read_Data.
- Accepts single or burst load/store requests from the core over a valid/ready handshake.
- Sequences the memory one word per cycle and returns load data over a valid/ready response channel.
- Sits between the CPU datapath (or a test/DMA agent) and the data memory unit, so no other block drives the memory ports directly.

---
 rtl/data_mem_requester_if.sv | 53 +++++
 rtl/data_mem_requester.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/data_mem_requester_if.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module      : data_mem_requester_if
// Description : Bundle of the request/response handshake channels and the
//               data-memory port driven by data_mem_requester.
//               master = core/agent plus memory side, slave = the requester.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface data_mem_requester_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
);
    // Request channel
    logic                  Req_Valid;
    logic                  Req_Ready;
    logic                  Req_Write;
    logic [ADDR_WIDTH-1:0] Req_Addr;
    logic [DATA_WIDTH-1:0] Req_Data;
    logic                  Req_Incr;
    logic [LEN_WIDTH-1:0]  Req_Len;

    // Load response channel
    logic                  Resp_Valid;
    logic                  Resp_Ready;
    logic [DATA_WIDTH-1:0] Resp_Data;
    logic                  Resp_Last;

    // Burst completion
    logic                  Done;

    // Data memory port
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] Write_Data;
    logic                  MemWrite;
    logic [DATA_WIDTH-1:0] Read_Data;

    modport master (
        output Req_Valid, Req_Write, Req_Addr, Req_Data, Req_Incr, Req_Len,
        output Resp_Ready, Read_Data,
        input  Req_Ready, Resp_Valid, Resp_Data, Resp_Last, Done,
        input  Address, Write_Data, MemWrite
    );

    modport slave (
        input  Req_Valid, Req_Write, Req_Addr, Req_Data, Req_Incr, Req_Len,
        input  Resp_Ready, Read_Data,
        output Req_Ready, Resp_Valid, Resp_Data, Resp_Last, Done,
        output Address, Write_Data, MemWrite
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_requester.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module      : data_mem_requester
// Description : Initiator-side controller for the data memory. Accepts single
//               or burst load/store requests, sequences the memory one word per
//               cycle and returns load data over a valid/ready response channel.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module data_mem_requester #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  wire logic             Clk,
    input  wire logic             Reset,
    data_mem_requester_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]  c_BEAT_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q;
    logic                   req_ready_q;
    logic                   resp_valid_q;
    logic                   resp_last_q;
    logic                   done_q;
    logic                   mem_write_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  resp_data_q;
    logic [LEN_WIDTH-1:0]   beat_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic                   incr_q;

    // Next-beat values; all arithmetic wraps naturally at the register width.
    logic                   w_last_beat;
    logic                   w_slot_free;
    logic [ADDR_WIDTH-1:0]  w_addr_d;
    logic [DATA_WIDTH-1:0]  w_wdata_d;
    logic [LEN_WIDTH-1:0]   w_beat_d;

    assign w_last_beat = (beat_q == len_q);
    // The response register can take a new word when empty or being drained.
    assign w_slot_free = !resp_valid_q || bus.Resp_Ready;
    assign w_addr_d    = addr_q + c_ADDR_ONE;
    assign w_wdata_d   = wdata_q + {{(DATA_WIDTH-1){1'b0}}, incr_q};
    assign w_beat_d    = beat_q + c_BEAT_ONE;

    // Main controller: state, memory drive and response registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            done_q       <= 1'b0;
            mem_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_data_q  <= '0;
            beat_q       <= '0;
            len_q        <= '0;
            incr_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    mem_write_q <= 1'b0;
                    if (bus.Req_Valid && req_ready_q) begin
                        // Request fields are captured here and never re-read.
                        addr_q      <= bus.Req_Addr;
                        wdata_q     <= bus.Req_Data;
                        incr_q      <= bus.Req_Incr;
                        len_q       <= bus.Req_Len;
                        beat_q      <= '0;
                        req_ready_q <= 1'b0;
                        if (bus.Req_Write) begin
                            state_q     <= S_WR;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q     <= S_RD;
                        end
                    end
                end

                S_WR: begin
                    // Every WR cycle commits one word at this edge.
                    if (w_last_beat) begin
                        state_q     <= S_FIN;
                        mem_write_q <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        beat_q  <= w_beat_d;
                        addr_q  <= w_addr_d;
                        wdata_q <= w_wdata_d;
                    end
                end

                S_RD: begin
                    if (resp_valid_q && resp_last_q) begin
                        // All words captured; wait for the final beat to drain.
                        if (bus.Resp_Ready) begin
                            resp_valid_q <= 1'b0;
                            resp_last_q  <= 1'b0;
                            state_q      <= S_FIN;
                            done_q       <= 1'b1;
                        end
                    end else if (w_slot_free) begin
                        resp_data_q  <= bus.Read_Data;
                        resp_valid_q <= 1'b1;
                        resp_last_q  <= w_last_beat;
                        // Address stays on the final word after its capture.
                        if (!w_last_beat) begin
                            addr_q <= w_addr_d;
                            beat_q <= w_beat_d;
                        end
                    end
                end

                S_FIN: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Req_Ready  = req_ready_q;
    assign bus.Resp_Valid = resp_valid_q;
    assign bus.Resp_Data  = resp_data_q;
    assign bus.Resp_Last  = resp_last_q;
    assign bus.Done       = done_q;
    assign bus.Address    = addr_q;
    assign bus.Write_Data = wdata_q;
    // Reset gates the strobe so the word in flight at a reset edge is dropped.
    assign bus.MemWrite   = mem_write_q && !Reset;

endmodule
`default_nettype wire
